// File: rtl/helen_onchip_arb.sv
// rtl/helen_onchip_arb.sv - two-requester arbiter in front of a single-port on-chip RAM
//
// Purpose: shares one single-port RAM between requesters m0 and m1. One access
// is granted per clock. The grant is combinational and uses a round-robin
// priority pointer. Read data returns exactly one clock after the grant.
//
// Ports:
//   clk, reset                 single clock, asynchronous active-high reset
//   mN_address/byteenable/
//   mN_read/write/writedata    requester N access (N = 0, 1)
//   mN_waitrequest             requester N is requesting but not granted
//   mN_readdata/readdatavalid  requester N read return, one clock after grant
//   ram_*                      drive side of the RAM; ram_readdata is its unregistered q
//   gntN_count                 saturating count of grants issued to requester N
module helen_onchip_arb #(
    parameter int  ADDR_W = 12,
    parameter int  DATA_W = 32,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic [15:0]       gnt0_count,
    output logic [15:0]       gnt1_count
);

    logic        req0, req1;
    logic        gnt0, gnt1;
    logic        ptr_q, ptr_d;        // 0: m0 favoured, 1: m1 favoured
    logic        rtag_v_q, rtag_v_d;
    logic        rtag_id_q, rtag_id_d;
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grants are gated by reset so that no RAM access is issued and no read
    // tag is captured while reset is high.
    assign gnt0 = ~reset & req0 & (~req1 | ~ptr_q);
    assign gnt1 = ~reset & req1 & (~req0 |  ptr_q);

    assign m0_waitrequest = req0 & ~gnt0;
    assign m1_waitrequest = req1 & ~gnt1;

    assign ram_clken = ~reset;

    always_comb begin
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        if (gnt0) begin
            ram_address    = m0_address;
            ram_byteenable = m0_write ? m0_byteenable : '1;
            ram_writedata  = m0_writedata;
            ram_chipselect = 1'b1;
            ram_write      = m0_write;
        end else if (gnt1) begin
            ram_address    = m1_address;
            ram_byteenable = m1_write ? m1_byteenable : '1;
            ram_writedata  = m1_writedata;
            ram_chipselect = 1'b1;
            ram_write      = m1_write;
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        rtag_v_d  = 1'b0;
        rtag_id_d = rtag_id_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        if (gnt0) begin
            ptr_d     = 1'b1;
            rtag_v_d  = ~m0_write;    // write wins when both strobes are high
            rtag_id_d = 1'b0;
            if (cnt0_q != 16'hFFFF) begin
                cnt0_d = cnt0_q + 16'd1;
            end
        end else if (gnt1) begin
            ptr_d     = 1'b0;
            rtag_v_d  = ~m1_write;
            rtag_id_d = 1'b1;
            if (cnt1_q != 16'hFFFF) begin
                cnt1_d = cnt1_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= 1'b0;
            rtag_v_q  <= 1'b0;
            rtag_id_q <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rtag_v_q  <= rtag_v_d;
            rtag_id_q <= rtag_id_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    assign m0_readdatavalid = rtag_v_q & ~rtag_id_q;
    assign m1_readdatavalid = rtag_v_q &  rtag_id_q;
    assign m0_readdata      = m0_readdatavalid ? ram_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? ram_readdata : '0;

    assign gnt0_count = cnt0_q;
    assign gnt1_count = cnt1_q;

endmodule

// File: tb/tb_helen_onchip_arb.sv
// tb/tb_helen_onchip_arb.sv - randomized and directed self-checking bench for helen_onchip_arb
module tb_helen_onchip_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_readdata;
    logic [15:0] gnt0_count, gnt1_count;

    always #5 clk = ~clk;

    helen_onchip_arb #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
        .gnt0_count(gnt0_count), .gnt1_count(gnt1_count)
    );

    // Single-port RAM: address registered on access, q unregistered.
    logic [31:0] mem [0:4095];
    logic [11:0] rd_addr_q = '0;
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
                end
            end
            rd_addr_q <= ram_address;
        end
    end
    assign ram_readdata = mem[rd_addr_q];

    // Reference model state
    logic [31:0] shadow [0:4095];
    int          mptr, mcnt0, mcnt1;
    logic        mpend_v;
    int          mpend_id;
    logic [31:0] mpend_data;
    logic        ew0, ew1;
    logic        seen_w0, seen_w1, seen_cs, seen_we, seen_rdv0, seen_rdv1;
    logic [31:0] seen_rd1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Called after a posedge with inputs set; checks at the negedge, advances
    // the model across the next posedge.
    task automatic step();
        logic        rq [2];
        logic        wr [2];
        logic [11:0] ad [2];
        logic [3:0]  be [2];
        logic [31:0] wd [2];
        logic        e_rdv0, e_rdv1;
        int          g;
        @(negedge clk);
        rq[0] = m0_read | m0_write; wr[0] = m0_write; ad[0] = m0_address;
        be[0] = m0_byteenable; wd[0] = m0_writedata;
        rq[1] = m1_read | m1_write; wr[1] = m1_write; ad[1] = m1_address;
        be[1] = m1_byteenable; wd[1] = m1_writedata;
        if (reset) begin
            mptr = 0; mcnt0 = 0; mcnt1 = 0; mpend_v = 1'b0;
        end
        g = -1;
        if (!reset) begin
            if (rq[0] && rq[1]) g = mptr;
            else if (rq[0]) g = 0;
            else if (rq[1]) g = 1;
        end
        ew0 = rq[0] && (g != 0);
        ew1 = rq[1] && (g != 1);
        e_rdv0 = mpend_v && (mpend_id == 0);
        e_rdv1 = mpend_v && (mpend_id == 1);
        chk("wait0", {31'd0, m0_waitrequest}, {31'd0, ew0});
        chk("wait1", {31'd0, m1_waitrequest}, {31'd0, ew1});
        chk("ram_cs", {31'd0, ram_chipselect}, (g >= 0) ? 32'd1 : 32'd0);
        chk("ram_we", {31'd0, ram_write}, (g >= 0) ? {31'd0, wr[g]} : 32'd0);
        chk("ram_addr", {20'd0, ram_address}, (g >= 0) ? {20'd0, ad[g]} : 32'd0);
        chk("ram_be", {28'd0, ram_byteenable}, (g < 0) ? 32'd0 : (wr[g] ? {28'd0, be[g]} : 32'hF));
        chk("ram_wdata", ram_writedata, (g >= 0) ? wd[g] : 32'd0);
        chk("ram_clken", {31'd0, ram_clken}, reset ? 32'd0 : 32'd1);
        chk("rdv0", {31'd0, m0_readdatavalid}, {31'd0, e_rdv0});
        chk("rdv1", {31'd0, m1_readdatavalid}, {31'd0, e_rdv1});
        chk("rdata0", m0_readdata, e_rdv0 ? mpend_data : 32'd0);
        chk("rdata1", m1_readdata, e_rdv1 ? mpend_data : 32'd0);
        chk("cnt0", {16'd0, gnt0_count}, mcnt0);
        chk("cnt1", {16'd0, gnt1_count}, mcnt1);
        seen_w0 = m0_waitrequest; seen_w1 = m1_waitrequest;
        seen_cs = ram_chipselect; seen_we = ram_write;
        seen_rdv0 = m0_readdatavalid; seen_rdv1 = m1_readdatavalid;
        seen_rd1 = m1_readdata;
        mpend_v = 1'b0;
        if (g >= 0) begin
            mptr = 1 - g;
            if (g == 0 && mcnt0 < 65535) mcnt0++;
            if (g == 1 && mcnt1 < 65535) mcnt1++;
            if (wr[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[g][b]) shadow[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
                end
            end else begin
                mpend_v = 1'b1; mpend_id = g; mpend_data = shadow[ad[g]];
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        mptr = 0; mcnt0 = 0; mcnt1 = 0; mpend_v = 1'b0; mpend_id = 0; mpend_data = '0;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        step();
        step();
        reset = 1'b0;

        // Both read continuously: grants alternate starting with m0.
        m0_read = 1; m0_address = 12'h001;
        m1_read = 1; m1_address = 12'h002;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("alt_w0", {31'd0, seen_w0}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("alt_w1", {31'd0, seen_w1}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        chk("alt_cnt0", {16'd0, gnt0_count}, 32'd3);
        chk("alt_cnt1", {16'd0, gnt1_count}, 32'd3);

        // Single write from m0 after a fresh reset.
        idle_inputs();
        do_reset();
        m0_write = 1; m0_address = 12'h005; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
        step();
        chk("wr_w0", {31'd0, seen_w0}, 32'd0);
        chk("wr_cs", {31'd0, seen_cs}, 32'd1);
        chk("wr_we", {31'd0, seen_we}, 32'd1);
        chk("wr_cnt0", {16'd0, gnt0_count}, 32'd1);

        // Read-back from m1.
        idle_inputs();
        m1_read = 1; m1_address = 12'h005;
        step();
        idle_inputs();
        step();
        chk("rb_rdv1", {31'd0, seen_rdv1}, 32'd1);
        chk("rb_data1", seen_rd1, 32'hDEADBEEF);
        chk("rb_rdv0", {31'd0, seen_rdv0}, 32'd0);

        // Read and write together from m1: the write wins.
        m1_read = 1; m1_write = 1; m1_address = 12'h010; m1_writedata = 32'h12345678;
        m1_byteenable = 4'hF;
        step();
        chk("rw_we", {31'd0, seen_we}, 32'd1);
        idle_inputs();
        step();
        chk("rw_rdv1", {31'd0, seen_rdv1}, 32'd0);

        // Reset arriving while a granted read is in flight.
        m0_read = 1; m0_address = 12'h005;
        @(negedge clk);
        chk("rst_gnt", {31'd0, ram_chipselect}, 32'd1);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        step();
        reset = 1'b0;
        step();
        chk("rst_rdv0", {31'd0, seen_rdv0}, 32'd0);
        chk("rst_cnt0", {16'd0, gnt0_count}, 32'd0);
        chk("rst_cnt1", {16'd0, gnt1_count}, 32'd0);
        m0_read = 1; m1_read = 1;
        step();
        chk("rst_fav_w0", {31'd0, seen_w0}, 32'd0);
        chk("rst_fav_w1", {31'd0, seen_w1}, 32'd1);
        idle_inputs();
        step();

        // Randomized traffic; a waiting requester holds its inputs.
        for (int i = 0; i < 2000; i++) begin
            if (!ew0) begin
                m0_read = 0; m0_write = 0;
                if ($urandom_range(0, 9) < 7) begin
                    case ($urandom_range(0, 2))
                        0: m0_read = 1;
                        1: m0_write = 1;
                        default: begin m0_read = 1; m0_write = 1; end
                    endcase
                end
                m0_address = 12'($urandom_range(0, 15));
                m0_byteenable = 4'($urandom);
                m0_writedata = $urandom;
            end
            if (!ew1) begin
                m1_read = 0; m1_write = 0;
                if ($urandom_range(0, 9) < 7) begin
                    case ($urandom_range(0, 2))
                        0: m1_read = 1;
                        1: m1_write = 1;
                        default: begin m1_read = 1; m1_write = 1; end
                    endcase
                end
                m1_address = 12'($urandom_range(0, 15));
                m1_byteenable = 4'($urandom);
                m1_writedata = $urandom;
            end
            step();
        end

        // Saturation of the m0 grant counter.
        idle_inputs();
        m0_read = 1; m0_address = 12'h003;
        for (int i = 0; i < 70000; i++) begin
            step();
        end
        chk("sat_cnt0", {16'd0, gnt0_count}, 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/helen_onchip_arb.md
HELEN_ONCHIP_ARB -- requirements
Module: helen_onchip_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; BE_W = DATA_W/8 derived, not overridable.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports mN_address  input  ADDR_W  requester N word address, N in {0,1}.
REQ-006 SHALL have ports mN_byteenable  input  BE_W  requester N write byte lanes.
REQ-007 SHALL have ports mN_read / mN_write  input  1 each  requester N access strobes.
REQ-008 SHALL have ports mN_writedata  input  DATA_W  requester N write data.
REQ-009 SHALL have ports mN_waitrequest  output  1  requester N must hold its request.
REQ-010 SHALL have ports mN_readdata  output  DATA_W  requester N read data.
REQ-011 SHALL have ports mN_readdatavalid  output  1  requester N read data valid.
REQ-012 SHALL have ports ram_address (ADDR_W), ram_byteenable (BE_W), ram_writedata (DATA_W), ram_chipselect, ram_write, ram_clken (1 each)  output  drive the single-port on-chip RAM.
REQ-013 SHALL have port ram_readdata  input  DATA_W  unregistered RAM q, valid one clk after address is sampled.
REQ-014 SHALL have ports gntN_count  output  16  saturating count of grants issued to requester N.

Function
REQ-015 SHALL treat requester N as requesting when mN_read or mN_write is high; if both high, SHALL perform the write and ignore the read.
REQ-016 SHALL grant at most one requester per cycle; grant is combinational from current requests and the priority pointer.
REQ-017 SHALL keep a 1-bit priority pointer naming the favoured requester; with both requesting, the favoured one wins; with one requesting, it wins regardless of pointer.
REQ-018 SHALL set the pointer to the non-granted requester on the clock edge after any grant; with no grant, pointer holds.
REQ-019 SHALL drive mN_waitrequest = request_N AND NOT grant_N; waitrequest SHALL be 0 when not requesting.
REQ-020 SHALL, on grant, drive ram_address/ram_byteenable/ram_writedata from the granted requester, ram_chipselect=1, ram_write=granted write; otherwise ram_chipselect=0, ram_write=0, other ram_* outputs = 0.
REQ-021 SHALL force ram_byteenable to all ones for granted reads.
REQ-022 SHALL drive ram_clken = 1 except while reset is high.
REQ-023 SHALL register a read-tag (valid bit + requester id) on each granted read; on the next cycle assert exactly the tagged mN_readdatavalid for one clk with mN_readdata = ram_readdata.
REQ-024 SHALL drive mN_readdata = 0 when mN_readdatavalid is 0.
REQ-025 SHALL sustain back-to-back grants (one access per clk); read latency SHALL be exactly 1 clk from grant to readdatavalid.
REQ-026 SHALL increment gntN_count by 1 per grant to N, saturating at 16'hFFFF (no wrap).
REQ-027 SHALL require that requester's inputs be held stable while its waitrequest is high; changes during wait SHALL simply be sampled at grant.

Reset
REQ-028 SHALL, while reset is high, force: pointer = 0 (requester 0 favoured), read-tag invalid, gntN_count = 0, all mN_readdatavalid = 0, ram_chipselect = 0, ram_write = 0, ram_clken = 0.
REQ-029 SHALL discard a read-tag captured in the cycle reset asserts; no readdatavalid SHALL appear after reset deassertion for a pre-reset read.
REQ-030 SHALL issue grants in the first cycle after reset deassertion.

Verification
REQ-031 Single write: m0 writes addr 0x005, data 0xDEADBEEF, be 4'b1111 -> m0_waitrequest 0, ram_chipselect=1, ram_write=1 same cycle; gnt0_count=1.
REQ-032 Read-back: m1 reads addr 0x005 after REQ-031 -> m1_readdatavalid high exactly 1 clk later, m1_readdata=0xDEADBEEF, m0_readdatavalid stays 0.
REQ-033 Contention: both read continuously for 6 clk after reset -> grants alternate m0,m1,m0,m1,m0,m1; each waitrequest high on alternate cycles; gnt0_count=gnt1_count=3.
REQ-034 Saturation: force 70000 m0 grants -> gnt0_count stops at 0xFFFF.
REQ-035 Reset mid-read: grant m0 read, assert reset before next edge -> no m0_readdatavalid after reset release; all counters 0; pointer favours m0.
REQ-036 Read+write same cycle from m1 with addr 0x010 -> ram_write=1, no m1_readdatavalid next cycle.
